dmem_access_ctrl: RTL and testbench

Sequences MEM-stage data-memory accesses for the pipelined core and shares the single data-memory port between the core and a debug/DMA requester. Consumes the memWrite/memType/ALUResult/writeData fields leaving the EX/MEM register. Drives a req/gnt/rvalid memory handshake and raises a stall that freezes the pipeline until the access completes. Gives the core priority, with a starvation guard for the debug port.

---
 rtl/dmem_access_ctrl_pkg.sv | 25 ++
 rtl/dmem_access_ctrl_if.sv | 28 ++
 rtl/dmem_access_ctrl_starve_cnt.sv | 26 ++
 rtl/dmem_access_ctrl.sv | 122 ++++++++++++
 tb/tb_dmem_access_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: shared bus widths, FSM state encoding and the full-width
// access type used for debug transfers.
package dmem_access_ctrl_pkg;

    localparam int DATA_BUS_BITS     = 32;
    localparam int MEM_TYPE_BUS_BITS = 3;
    localparam int MT_FULL           = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CORE_REQ,
        ST_CORE_WAIT,
        ST_DBG_REQ,
        ST_DBG_WAIT
    } dmem_st_e;

    function automatic logic is_wait(dmem_st_e s);
        return s == ST_CORE_WAIT || s == ST_DBG_WAIT;
    endfunction

    function automatic logic is_dbg(dmem_st_e s);
        return s == ST_DBG_REQ || s == ST_DBG_WAIT;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: req/gnt/rvalid data-memory port; master issues, slave responds.
interface dmem_access_ctrl_if
    import dmem_access_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_BUS_BITS,
    parameter int MT_W   = MEM_TYPE_BUS_BITS
);

    logic              mem_req;
    logic              mem_we;
    logic [MT_W-1:0]   mem_type;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_type, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_type, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/dmem_access_ctrl_starve_cnt.sv
// dmem_access_ctrl_starve_cnt: saturating count of cycles the debug port waited, with clear.
module dmem_access_ctrl_starve_cnt #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    assign sat = cnt == W'(LIMIT);

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !sat)
            cnt <= cnt + 1'b1;

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory sequencer sharing one port between core and debug.
// Define DMEM_TIMEOUT_EN to add a response timeout with a sticky mem_err flag.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int DATA_W       = DATA_BUS_BITS,
    parameter int MT_W         = MEM_TYPE_BUS_BITS,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_valid,
    input  logic              core_we,
    input  logic [MT_W-1:0]   core_type,
    input  logic [DATA_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_valid,
    input  logic              dbg_we,
    input  logic [DATA_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic [DATA_W-1:0] dbg_rdata,
    dmem_access_ctrl_if.master mem,
    output logic              mem_err
);

    dmem_st_e          state;
    logic              starved;
    logic              dbg_win;
    logic              to_hit;
    logic              done;
    logic [DATA_W-1:0] rdata_eff;

    assign dbg_win    = dbg_valid && (!core_valid || starved);
    assign done       = is_wait(state) && (mem.mem_rvalid || to_hit);
    assign rdata_eff  = mem.mem_rvalid ? mem.mem_rdata : '0;
    assign core_stall = core_valid && !(state == ST_CORE_WAIT && done);
    assign core_rdata = (state == ST_CORE_WAIT && done) ? rdata_eff : '0;
    assign dbg_ready  = state == ST_DBG_WAIT && done;

    dmem_access_ctrl_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk  (clk),
        .reset(reset),
        .inc  (dbg_valid && !is_dbg(state)),
        .clr  (state == ST_IDLE && dbg_win),
        .sat  (starved)
    );

    // Request fields are captured on the IDLE exit so they stay stable until gnt.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state         <= ST_IDLE;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_type  <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            dbg_rdata     <= '0;
        end else begin
            case (state)
                ST_IDLE:
                    if (dbg_win) begin
                        state         <= ST_DBG_REQ;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= dbg_we;
                        mem.mem_type  <= MT_W'(MT_FULL);
                        mem.mem_addr  <= dbg_addr;
                        mem.mem_wdata <= dbg_wdata;
                    end else if (core_valid) begin
                        state         <= ST_CORE_REQ;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= core_we;
                        mem.mem_type  <= core_type;
                        mem.mem_addr  <= core_addr;
                        mem.mem_wdata <= core_wdata;
                    end
                ST_CORE_REQ, ST_DBG_REQ:
                    if (mem.mem_gnt) begin
                        state       <= state == ST_CORE_REQ ? ST_CORE_WAIT : ST_DBG_WAIT;
                        mem.mem_req <= 1'b0;
                    end
                ST_CORE_WAIT:
                    if (done)
                        state <= ST_IDLE;
                ST_DBG_WAIT:
                    if (done) begin
                        state     <= ST_IDLE;
                        dbg_rdata <= rdata_eff;
                    end
                default:
                    state <= ST_IDLE;
            endcase
        end

`ifdef DMEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt;

    assign to_hit = is_wait(state) && tcnt == TW'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            tcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            tcnt <= (is_wait(state) && !done) ? tcnt + 1'b1 : '0;
            if (to_hit && !mem.mem_rvalid)
                mem_err <= 1'b1;
        end
`else
    logic unused_timeout;

    assign unused_timeout = TIMEOUT != 0;
    assign to_hit         = 1'b0;
    assign mem_err        = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed table-driven bench plus hand sequences for arbitration,
// reset mid-access and (with DMEM_TIMEOUT_EN) the response timeout.
module tb_dmem_access_ctrl;

    typedef struct {
        logic [31:0] cv, cwe, ca, cwd, dv, dwe, da, dwd, g, v, rd;
        logic [31:0] st, rq, we, ty, a, wd, crd, dr, drd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_valid = 1'b0, core_we = 1'b0;
    logic [2:0]  core_type = 3'd1;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        dbg_valid = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        dbg_ready;
    logic [31:0] dbg_rdata;
    logic        mem_err;

    int nvec = 0;
    int nerr = 0;
    logic pend = 1'b0;

    dmem_access_ctrl_if #(.DATA_W(32), .MT_W(3)) mbus ();

    dmem_access_ctrl #(.DATA_W(32), .MT_W(3), .STARVE_LIMIT(8), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .core_valid(core_valid),
        .core_we   (core_we),
        .core_type (core_type),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .core_stall(core_stall),
        .core_rdata(core_rdata),
        .dbg_valid (dbg_valid),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ready (dbg_ready),
        .dbg_rdata (dbg_rdata),
        .mem       (mbus.master),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: grant every request at once, answer the cycle after the grant.
    task automatic resp();
        mbus.mem_rvalid = pend;
        mbus.mem_gnt    = mbus.mem_req;
        pend            = mbus.mem_req;
    endtask

    vec_t tv [24];

    initial begin
        int ncore, extra;
        logic got;
        tv[0]  = '{1,0,'h100,0,     0,0,0,0,     0,0,0,       1,0,0,0,'h000,0,0,0,0};
        tv[1]  = '{1,0,'h100,0,     0,0,0,0,     1,0,0,       1,1,0,1,'h100,0,0,0,0};
        tv[2]  = '{1,0,'h100,0,     0,0,0,0,     0,1,'hDEAD,  0,0,0,1,'h100,0,'hDEAD,0,0};
        tv[3]  = '{0,0,'h100,0,     0,0,0,0,     0,0,0,       0,0,0,1,'h100,0,0,0,0};
        tv[4]  = '{1,1,'h200,'h55AA,0,0,0,0,     0,0,0,       1,0,0,1,'h100,0,0,0,0};
        tv[5]  = '{1,1,'h200,'h55AA,0,0,0,0,     0,0,0,       1,1,1,1,'h200,'h55AA,0,0,0};
        tv[6]  = '{1,1,'h200,'h55AA,0,0,0,0,     0,0,0,       1,1,1,1,'h200,'h55AA,0,0,0};
        tv[7]  = '{1,1,'h200,'h55AA,0,0,0,0,     0,0,0,       1,1,1,1,'h200,'h55AA,0,0,0};
        tv[8]  = '{1,1,'h200,'h55AA,0,0,0,0,     1,0,0,       1,1,1,1,'h200,'h55AA,0,0,0};
        tv[9]  = '{1,1,'h200,'h55AA,0,0,0,0,     0,1,0,       0,0,1,1,'h200,'h55AA,0,0,0};
        tv[10] = '{0,1,'h200,'h55AA,0,0,0,0,     0,0,0,       0,0,1,1,'h200,'h55AA,0,0,0};
        tv[11] = '{1,0,'h300,0,     0,0,0,0,     0,0,0,       1,0,1,1,'h200,'h55AA,0,0,0};
        tv[12] = '{1,0,'h300,0,     0,0,0,0,     1,0,0,       1,1,0,1,'h300,0,0,0,0};
        tv[13] = '{0,0,'h300,0,     0,0,0,0,     0,0,0,       0,0,0,1,'h300,0,0,0,0};
        tv[14] = '{0,0,'h300,0,     0,0,0,0,     0,1,0,       0,0,0,1,'h300,0,0,0,0};
        tv[15] = '{1,0,'h400,0,     0,0,0,0,     0,0,0,       1,0,0,1,'h300,0,0,0,0};
        tv[16] = '{1,0,'h400,0,     0,0,0,0,     1,0,0,       1,1,0,1,'h400,0,0,0,0};
        tv[17] = '{1,0,'h400,0,     0,0,0,0,     0,1,'hBEEF,  0,0,0,1,'h400,0,'hBEEF,0,0};
        tv[18] = '{0,0,'h400,0,     0,0,0,0,     0,1,'hFFFF,  0,0,0,1,'h400,0,0,0,0};
        tv[19] = '{0,0,'h400,0,     0,0,0,0,     0,0,0,       0,0,0,1,'h400,0,0,0,0};
        tv[20] = '{0,0,0,0,         1,0,'h500,0, 0,0,0,       0,0,0,1,'h400,0,0,0,0};
        tv[21] = '{0,0,0,0,         1,0,'h500,0, 1,0,0,       0,1,0,2,'h500,0,0,0,0};
        tv[22] = '{0,0,0,0,         1,0,'h500,0, 0,1,'hCAFE,  0,0,0,2,'h500,0,0,1,0};
        tv[23] = '{0,0,0,0,         0,0,0,0,     0,0,0,       0,0,0,2,'h500,0,0,0,'hCAFE};

        mbus.mem_gnt = 1'b0;
        mbus.mem_rvalid = 1'b0;
        mbus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(mbus.mem_req), 0);
        chk("rst_addr", mbus.mem_addr, 0);
        chk("rst_stall", 32'(core_stall), 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        step();
        reset = 1'b1;

        for (int i = 0; i < 24; i++) begin
            core_valid = tv[i].cv[0];
            core_we = tv[i].cwe[0];
            core_addr = tv[i].ca;
            core_wdata = tv[i].cwd;
            dbg_valid = tv[i].dv[0];
            dbg_we = tv[i].dwe[0];
            dbg_addr = tv[i].da;
            dbg_wdata = tv[i].dwd;
            mbus.mem_gnt = tv[i].g[0];
            mbus.mem_rvalid = tv[i].v[0];
            mbus.mem_rdata = tv[i].rd;
            @(negedge clk);
            chk($sformatf("r%0d_stall", i), 32'(core_stall), tv[i].st);
            chk($sformatf("r%0d_req", i), 32'(mbus.mem_req), tv[i].rq);
            chk($sformatf("r%0d_we", i), 32'(mbus.mem_we), tv[i].we);
            chk($sformatf("r%0d_type", i), 32'(mbus.mem_type), tv[i].ty);
            chk($sformatf("r%0d_addr", i), mbus.mem_addr, tv[i].a);
            chk($sformatf("r%0d_wdata", i), mbus.mem_wdata, tv[i].wd);
            chk($sformatf("r%0d_core_rdata", i), core_rdata, tv[i].crd);
            chk($sformatf("r%0d_dbg_ready", i), 32'(dbg_ready), tv[i].dr);
            chk($sformatf("r%0d_dbg_rdata", i), dbg_rdata, tv[i].drd);
            step();
        end

        // Both requesters held: core wins until the starve counter saturates.
        core_valid = 1'b1; core_we = 1'b0; core_addr = 'h600;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 'h700;
        mbus.mem_gnt = 1'b0; mbus.mem_rvalid = 1'b0; mbus.mem_rdata = 'h77;
        pend = 1'b0; ncore = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            resp();
            @(negedge clk);
            if (dbg_ready) got = 1'b1;
            else if (!core_stall) ncore++;
            step();
        end
        chk("starve_dbg_granted", 32'(got), 1);
        chk("starve_core_wins", ncore, 3);
        dbg_valid = 1'b0;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            resp();
            @(negedge clk);
            extra += int'(dbg_ready);
            step();
        end
        chk("dbg_ready_single_pulse", extra, 0);
        chk("starve_dbg_rdata", dbg_rdata, 'h77);
        core_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            resp();
            step();
        end
        mbus.mem_gnt = 1'b0; mbus.mem_rvalid = 1'b0; pend = 1'b0;

        // Reset in CORE_WAIT, then a stray rvalid after release.
        core_valid = 1'b1; core_addr = 'h800;
        step();
        mbus.mem_gnt = 1'b1;
        step();
        mbus.mem_gnt = 1'b0; core_valid = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("rstmid_req", 32'(mbus.mem_req), 0);
        chk("rstmid_addr", mbus.mem_addr, 0);
        chk("rstmid_type", 32'(mbus.mem_type), 0);
        chk("rstmid_dbg_rdata", dbg_rdata, 0);
        step();
        reset = 1'b1; mbus.mem_rvalid = 1'b1; mbus.mem_rdata = 'h99;
        @(negedge clk);
        chk("stray_core_rdata", core_rdata, 0);
        chk("stray_dbg_ready", 32'(dbg_ready), 0);
        step();
        mbus.mem_rvalid = 1'b0; core_valid = 1'b1; core_addr = 'h900;
        @(negedge clk);
        chk("post_rst_idle_stall", 32'(core_stall), 1);
        chk("post_rst_idle_req", 32'(mbus.mem_req), 0);
        step();
        mbus.mem_gnt = 1'b1;
        @(negedge clk);
        chk("post_rst_req", 32'(mbus.mem_req), 1);
        chk("post_rst_addr", mbus.mem_addr, 'h900);
        step();
        mbus.mem_gnt = 1'b0; mbus.mem_rvalid = 1'b1; mbus.mem_rdata = 'h42;
        @(negedge clk);
        chk("post_rst_stall", 32'(core_stall), 0);
        chk("post_rst_rdata", core_rdata, 'h42);
        step();
        mbus.mem_rvalid = 1'b0; core_valid = 1'b0;
        step();

`ifdef DMEM_TIMEOUT_EN
        core_valid = 1'b1; core_addr = 'hA00; mbus.mem_rdata = 'h5555;
        step();
        mbus.mem_gnt = 1'b1;
        step();
        mbus.mem_gnt = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            chk($sformatf("to_w%0d_stall", w), 32'(core_stall), w < 4 ? 1 : 0);
            chk($sformatf("to_w%0d_rdata", w), core_rdata, 0);
            chk($sformatf("to_w%0d_err", w), 32'(mem_err), 0);
            step();
        end
        core_valid = 1'b0;
        @(negedge clk);
        chk("to_err_set", 32'(mem_err), 1);
        chk("to_idle_req", 32'(mbus.mem_req), 0);
        core_valid = 1'b1; pend = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            resp();
            if (i == 3) core_valid = 1'b0;
            step();
        end
        mbus.mem_gnt = 1'b0; mbus.mem_rvalid = 1'b0;
        @(negedge clk);
        chk("to_err_sticky", 32'(mem_err), 1);
`else
        @(negedge clk);
        chk("mem_err_tied", 32'(mem_err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
